lsu_bus_port: RTL
=================

Name: lsu_bus_port

Overview:
- Data-side memory port of the core. It consumes the instruction decoder's memory controls (read strobe, write strobe, halfword/byte size flags, signed/unsigned flags) plus the ALU address and the rs2 store data.
- It runs one word-aligned req/ack transaction on the data bus per access and stalls the core until that access completes.
- It returns the aligned, sign- or zero-extended load result to write-back.
- Sits between the execute stage and the data memory / bus fabric.

Parameters:
- TIMEOUT_CYCLES, 255, wait cycles allowed for bus_ack before the access is aborted with an error.
- TMO_W, 8, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from decoder.
- mem_write  in  4  store request from decoder; any nonzero value means store, and the value itself is ignored.
- extend_h  in  1  halfword access.
- extend_b  in  1  byte access.
- sign  in  1  sign-extend load result.
- unsgn  in  1  zero-extend load result.
- addr  in  32  byte address from ALU.
- store_data  in  32  rs2 value.
- stall  out  1  hold PC and pipeline.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid this cycle.
- bus_err  out  1  one-cycle pulse when an access aborts (timeout or misalign).
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, with bits [1:0] equal to 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-aligned write data.
- bus_rdata  in  32  read data.
- bus_ack  in  1  one-cycle completion.

Behaviour:
- Access present: acc = mem_read | (mem_write != 0). If both read and write are asserted, the access is a store.
- Size selection: byte if extend_b, else half if extend_h, else word. extend_b wins if both are set.
- Byte enables: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 << {addr[1],1'b0}; word -> 4'b1111.
- Store data: bus_wdata = store_data replicated into every lane (byte x4, half x2, word as-is).
- FSM states IDLE, REQ, DONE.
- IDLE -> REQ when acc=1. Address, size, extension flags, we, be and wdata are registered on the transition.
- REQ: bus_req=1 with the registered fields held stable.
  - bus_ack=1 -> DONE; for a read, bus_rdata is captured that cycle.
  - Timeout counter reaches TIMEOUT_CYCLES -> DONE with an error flag set.
- DONE: exactly one cycle, then IDLE. load_valid=1 for a non-error read. bus_err=1 on error.
- stall = (IDLE & acc) | REQ. stall is 0 in DONE, so the core commits the instruction at the end of the DONE cycle. The next instruction is sampled in IDLE, giving one bubble-free return.
- Minimum access latency: 3 cycles (IDLE sample, REQ with same-cycle ack, DONE).
- Load extraction: shift the captured word right by 8*addr_q[1:0], then take [7:0], [15:0] or [31:0] by size.
- Extension: a sub-word load is sign-extended if sign=1, otherwise zero-extended (unsgn and lw-style neither-flag both zero-extend). Word loads are unchanged.
- On error, load_data = 0.
- Outside DONE, load_data holds its last value.
- bus_ack outside REQ is ignored.
- Timeout counter clears on entry to REQ.
- Reset (any state, including mid-REQ): state=IDLE; stall reflects inputs combinationally.
- Reset values:
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - load_data=0, load_valid=0, bus_err=0.
- An access abandoned by reset is not replayed.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> DONE directly with no bus request, bus_err=1, load_data=0, and stall for 1 cycle.
- Undefined: the low address bits are forced to the access alignment (half clears bit 0, word clears bits 1:0) and the access proceeds normally.

Decomposition:
- Shared package: FSM state encoding, size encoding (SZ_B, SZ_H, SZ_W), byte-enable/lane constants.
- One sub-module, lsu_load_align: combinational shift, select and sign/zero extension, reusable by a future cache.

Test Plan:
- lw at 0x100, ack on first REQ cycle, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111; DONE load_data=0xDEADBEEF; stall high exactly 2 cycles.
- lb sign=1 at 0x103, rdata=0x80FF1234 -> be=1000, load_data=0xFFFFFF80. Repeat as lbu (unsgn=1) -> 0x00000080.
- sh at 0x202, store_data=0x0000ABCD -> bus_we=1, bus_addr=0x200, be=1100, wdata=0xABCDABCD; load_valid stays 0.
- No bus_ack for TIMEOUT_CYCLES -> bus_err pulse, load_data=0, return to IDLE; a late ack is ignored.
- rst_n low mid-REQ -> bus_req=0 and all outputs at reset values asynchronously; after release, the next lw completes normally.
- lw at 0x102: with MISALIGN_TRAP_EN, no bus_req and bus_err=1; without it, bus_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_bus_port_pkg.sv
// Shared types and helpers for the load/store bus port.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lsu_bus_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Byte enables for an access of the given size at byte offset ofs.
  function automatic logic [3:0] be_of(input size_t size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      SZ_B:    be = BE_BYTE << ofs;
      SZ_H:    be = BE_HALF << {ofs[1], 1'b0};
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the byte enables pick the right one.
  function automatic logic [31:0] wdata_of(input size_t size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_bus_port_load_align.sv
// Load alignment: shifts the bus word down to the addressed lane, then sign/zero extends.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module lsu_load_align
  import lsu_bus_port_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  ofs,
  input  size_t       size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Bring the addressed byte to lane 0, then keep only the access width.
  always_comb begin
    shifted = word >> {ofs, 3'b000};
    data    = shifted;
    case (size)
      SZ_B:    data = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_port.sv
// Data-side memory port: one word-aligned req/ack bus transaction per load or store.
// Latency: 3 cycles minimum (IDLE sample, REQ with same-cycle ack, DONE); timeout aborts.
// Backpressure: stall holds the core from access sample until DONE. Option: MISALIGN_TRAP_EN.
module lsu_bus_port
  import lsu_bus_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic [3:0]  mem_write,
  input  logic        extend_h,
  input  logic        extend_b,
  input  logic        sign,
  input  logic        unsgn,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic              acc, we_in;
  size_t             size_in, size_q;
  logic [31:0]       addr_al, addr_q;
  logic              sign_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [31:0]       align_out;
  logic              tmo_hit;

  // Zero extension is simply "not sign"; unsgn carries no extra information.
  logic unused_unsgn;
  assign unused_unsgn = unsgn;

  assign acc   = mem_read | (|mem_write);
  assign we_in = |mem_write;
  assign tmo_hit = (tmo_q == TMO_LIMIT);

  // Size decode (byte beats half) and natural alignment of the address.
  always_comb begin
    size_in = SZ_W;
    if (extend_b)      size_in = SZ_B;
    else if (extend_h) size_in = SZ_H;
    addr_al = addr;
    case (size_in)
      SZ_H:    addr_al = {addr[31:1], 1'b0};
      SZ_W:    addr_al = {addr[31:2], 2'b00};
      default: addr_al = addr;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misal;
  // Half on an odd byte, or word off a word boundary, traps instead of going to the bus.
  always_comb begin
    misal = ((size_in == SZ_H) && addr[0]) || ((size_in == SZ_W) && (addr[1:0] != 2'b00));
  end
`endif

  lsu_load_align u_align (
    .word (bus_rdata),
    .ofs  (addr_q[1:0]),
    .size (size_q),
    .sign (sign_q),
    .data (align_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the combinational handshake outputs.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = acc;
        if (acc) begin
`ifdef MISALIGN_TRAP_EN
          state_d = misal ? ST_DONE : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || tmo_hit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access capture, timeout counting and write-back result/pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= SZ_W;
      sign_q     <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      tmo_q      <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            addr_q    <= addr_al;
            size_q    <= size_in;
            sign_q    <= sign;
            bus_we    <= we_in;
            bus_be    <= be_of(size_in, addr_al[1:0]);
            bus_wdata <= wdata_of(size_in, store_data);
            tmo_q     <= '0;
`ifdef MISALIGN_TRAP_EN
            if (misal) begin
              load_data <= '0;
              bus_err   <= 1'b1;
            end
`endif
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              load_data  <= align_out;
              load_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            load_data <= '0;
            bus_err   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          load_valid <= 1'b0;
          bus_err    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_addr = {addr_q[31:2], 2'b00};

endmodule
